mandel_iter_engine: RTL and testbench

- Escape-time iteration engine directly upstream of the colour-mapping stage.
- Accepts one complex point c = cr + i·ci per handshake and iterates z(n+1) = z(n)² + c from z(0) = 0.
- Emits the iteration count that the colour mapper consumes as iter_i, plus a pass-through pixel tag.
- Computes one iteration per clock; one point in flight at a time.

---
 rtl/mandel_pkg.sv | 20 ++
 rtl/complex_sq_add.sv | 50 +++++
 rtl/mandel_iter_engine.sv | 144 ++++++++++++++
 tb/tb_mandel_iter_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and default sizing for the escape-time iteration engine.
package mandel_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int FRAC_BITS      = 28;
    localparam int MAX_ITER_WIDTH = 16;
    localparam int TAG_WIDTH      = 22;

    // |z|^2 above 4.0 means the orbit is guaranteed to diverge.
    localparam logic [DATA_WIDTH:0] ESCAPE_THRESH = (DATA_WIDTH + 1)'(4) << FRAC_BITS;

    typedef logic signed [DATA_WIDTH-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/complex_sq_add.sv
// One Mandelbrot step, combinational: next_z = z^2 + c, plus |z|^2 of the current z.
// Holds all three multipliers so this datapath can later be pipelined without touching the FSM.
module complex_sq_add #(
    parameter int DATA_WIDTH = mandel_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = mandel_pkg::FRAC_BITS
) (
    input  logic signed [DATA_WIDTH-1:0] zr_i,
    input  logic signed [DATA_WIDTH-1:0] zi_i,
    input  logic signed [DATA_WIDTH-1:0] cr_i,
    input  logic signed [DATA_WIDTH-1:0] ci_i,
    output logic signed [DATA_WIDTH-1:0] next_zr_o,
    output logic signed [DATA_WIDTH-1:0] next_zi_o,
    output logic        [DATA_WIDTH:0]   mag_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] zr_ext, zi_ext, cr_ext, ci_ext;
    logic signed [PW-1:0] zr_sq_full, zi_sq_full, zrzi_full;
    logic signed [PW-1:0] zr_sq, zi_sq;
    logic        [PW-1:0] mag_wide;

    // Full-width signed products, rescaled by arithmetic shift (truncation toward -inf).
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
        zr_ext     = {{DATA_WIDTH{zr_i[DATA_WIDTH-1]}}, zr_i};
        zi_ext     = {{DATA_WIDTH{zi_i[DATA_WIDTH-1]}}, zi_i};
        cr_ext     = {{DATA_WIDTH{cr_i[DATA_WIDTH-1]}}, cr_i};
        ci_ext     = {{DATA_WIDTH{ci_i[DATA_WIDTH-1]}}, ci_i};

        zr_sq_full = zr_ext * zr_ext;
        zi_sq_full = zi_ext * zi_ext;
        zrzi_full  = zr_ext * zi_ext;

        zr_sq      = zr_sq_full >>> FRAC_BITS;
        zi_sq      = zi_sq_full >>> FRAC_BITS;

        next_zr_o  = DATA_WIDTH'(zr_sq - zi_sq + cr_ext);
        next_zi_o  = DATA_WIDTH'(((zrzi_full <<< 1) >>> FRAC_BITS) + ci_ext);

        // Both squares are non-negative; saturate so a huge |z| can never wrap below the threshold.
        mag_wide   = PW'(zr_sq + zi_sq);
        if (|mag_wide[PW-1:DATA_WIDTH+1]) begin
            mag_o = '1;
        end else begin
            mag_o = mag_wide[DATA_WIDTH:0];
        end
    end

endmodule

// File: rtl/mandel_iter_engine.sv
// Escape-time iteration engine: accepts one point c, iterates z = z^2 + c one step per
// clock until |z|^2 > 4 or the iteration limit, then holds the result for the colour mapper.
module mandel_iter_engine
    import mandel_pkg::*;
#(
    parameter int DATA_WIDTH     = mandel_pkg::DATA_WIDTH,
    parameter int FRAC_BITS      = mandel_pkg::FRAC_BITS,
    parameter int MAX_ITER_WIDTH = mandel_pkg::MAX_ITER_WIDTH,
    parameter int TAG_WIDTH      = mandel_pkg::TAG_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     cr_i,
    input  logic [DATA_WIDTH-1:0]     ci_i,
    input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [MAX_ITER_WIDTH-1:0] iter_o,
    output logic                      escaped_o,
    output logic [TAG_WIDTH-1:0]      tag_o,
    output logic                      valid_o,
    input  logic                      ready_i
);

    localparam logic [DATA_WIDTH:0] ESC_LIMIT = (DATA_WIDTH + 1)'(4) << FRAC_BITS;

    state_t                      state_q, state_d;
    logic signed [DATA_WIDTH-1:0] zr_q, zr_d, zi_q, zi_d;
    logic signed [DATA_WIDTH-1:0] cr_q, cr_d, ci_q, ci_d;
    logic [MAX_ITER_WIDTH-1:0]    n_q, n_d, limit_q, limit_d;
    logic [MAX_ITER_WIDTH-1:0]    iter_q, iter_d;
    logic                         escaped_q, escaped_d;
    logic                         valid_q, valid_d;
    logic [TAG_WIDTH-1:0]         tag_q, tag_d;

    logic signed [DATA_WIDTH-1:0] next_zr, next_zi;
    logic        [DATA_WIDTH:0]   mag;

    complex_sq_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_step (
        .zr_i      (zr_q),
        .zi_i      (zi_q),
        .cr_i      (cr_q),
        .ci_i      (ci_q),
        .next_zr_o (next_zr),
        .next_zi_o (next_zi),
        .mag_o     (mag)
    );

    // Only IDLE accepts; reset masks ready so nothing is taken while the engine is held.
    assign ready_o   = (state_q == IDLE) && !rst_i;
    assign valid_o   = valid_q;
    assign iter_o    = iter_q;
    assign escaped_o = escaped_q;
    assign tag_o     = tag_q;

    // Next-state and datapath update: limit check has priority over the escape test.
    always_comb begin
        state_d   = state_q;
        zr_d      = zr_q;
        zi_d      = zi_q;
        cr_d      = cr_q;
        ci_d      = ci_q;
        n_d       = n_q;
        limit_d   = limit_q;
        iter_d    = iter_q;
        escaped_d = escaped_q;
        valid_d   = valid_q;
        tag_d     = tag_q;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    cr_d    = cr_i;
                    ci_d    = ci_i;
                    limit_d = max_iter_i;
                    tag_d   = tag_i;
                    zr_d    = '0;
                    zi_d    = '0;
                    n_d     = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (n_q == limit_q) begin
                    iter_d    = n_q;
                    escaped_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end else if (mag > ESC_LIMIT) begin
                    iter_d    = n_q;
                    escaped_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end else begin
                    zr_d = next_zr;
                    zi_d = next_zi;
                    n_d  = n_q + 1'b1;
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any point in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            zr_q      <= '0;
            zi_q      <= '0;
            cr_q      <= '0;
            ci_q      <= '0;
            n_q       <= '0;
            limit_q   <= '0;
            iter_q    <= '0;
            escaped_q <= 1'b0;
            valid_q   <= 1'b0;
            tag_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            state_q   <= state_d;
            zr_q      <= zr_d;
            zi_q      <= zi_d;
            cr_q      <= cr_d;
            ci_q      <= ci_d;
            n_q       <= n_d;
            limit_q   <= limit_d;
            iter_q    <= iter_d;
            escaped_q <= escaped_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
        end
    end

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Directed bench for mandel_iter_engine: known orbits, limit/escape boundaries,
// backpressure and mid-iteration reset.
module tb_mandel_iter_engine;

    localparam int DW = 32;
    localparam int MW = 16;
    localparam int TW = 22;

    localparam logic [DW-1:0] Q_ZERO = 32'h0000_0000;
    localparam logic [DW-1:0] Q_HALF = 32'h0800_0000;
    localparam logic [DW-1:0] Q_ONE  = 32'h1000_0000;
    localparam logic [DW-1:0] Q_1P5  = 32'h1800_0000;
    localparam logic [DW-1:0] Q_M2   = 32'hE000_0000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] cr_i, ci_i;
    logic [MW-1:0] max_iter_i;
    logic [TW-1:0] tag_i;
    logic          valid_i, ready_i;
    logic          ready_o, escaped_o, valid_o;
    logic [MW-1:0] iter_o;
    logic [TW-1:0] tag_o;

    int tests_run    = 0;
    int tests_failed = 0;

    mandel_iter_engine #(
        .DATA_WIDTH     (DW),
        .FRAC_BITS      (28),
        .MAX_ITER_WIDTH (MW),
        .TAG_WIDTH      (TW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cr_i       (cr_i),
        .ci_i       (ci_i),
        .max_iter_i (max_iter_i),
        .tag_i      (tag_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .iter_o     (iter_o),
        .escaped_o  (escaped_o),
        .tag_o      (tag_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string         name;
        logic [DW-1:0] cr;
        logic [DW-1:0] ci;
        logic [MW-1:0] mi;
        logic [TW-1:0] tag;
        int            lat;
        logic [MW-1:0] iter;
        logic          esc;
    } vec_t;

    // Present one point, wait for acceptance, then count edges until valid_o (bounded).
    task automatic send_point(input logic [DW-1:0] cr, input logic [DW-1:0] ci,
                              input logic [MW-1:0] mi, input logic [TW-1:0] tg,
                              input int budget, output int lat);
        int w;
        @(negedge clk_i);
        w = 0;
        while (!ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        cr_i = cr; ci_i = ci; max_iter_i = mi; tag_i = tg; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < budget) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        cr_i = '0; ci_i = '0; max_iter_i = '0; tag_i = '0;
        #2;
        tests_run++;
        if (valid_o !== 1'b0 || iter_o !== '0 || escaped_o !== 1'b0 || tag_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b iter=%0d esc=%b tag=%h, required all zero",
                     valid_o, iter_o, escaped_o, tag_o);
        end
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: ready_o=%b, required 0 during reset", ready_o);
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: ready_o=%b, required 1 in IDLE", ready_o);
        end
    endtask

    task automatic test_directed_vectors();
        vec_t vecs[7];
        int   lat;
        // Orbit stays at 0: runs to the limit, valid_o 101 edges after accept.
        vecs[0] = '{"origin_limit", Q_ZERO, Q_ZERO, 16'd100, 22'h12345, 101, 16'd100, 1'b0};
        // z: 0, 1.5, 3.75 -> |z|^2 = 14.06 escapes with n = 2.
        vecs[1] = '{"escape_1p5", Q_1P5, Q_ZERO, 16'd50, 22'h00A5A, 3, 16'd2, 1'b1};
        // z: 0, -2, 2, 2, ... |z|^2 sits at exactly 4.0 and never escapes.
        vecs[2] = '{"mag_eq_4", Q_M2, Q_ZERO, 16'd20, 22'h3FFFF, 21, 16'd20, 1'b0};
        // Zero limit terminates on the first ITER cycle.
        vecs[3] = '{"zero_limit", Q_HALF, Q_HALF, 16'd0, 22'h2AAAA, 1, 16'd0, 1'b0};
        // Limit reached at n = 2 on the same cycle the escape test would fire: limit wins.
        vecs[4] = '{"limit_before_escape", Q_1P5, Q_ZERO, 16'd2, 22'h01234, 3, 16'd2, 1'b0};
        // z: 0, 1+i, 1+3i -> |z|^2 = 10 escapes with n = 2 (exercises the cross product).
        vecs[5] = '{"escape_1p1i", Q_ONE, Q_ONE, 16'd50, 22'h15555, 3, 16'd2, 1'b1};
        // z: 0, i, -1+i, -i, -1+i, ... bounded cycle, runs to the limit.
        vecs[6] = '{"bounded_i", Q_ZERO, Q_ONE, 16'd10, 22'h0BEEF, 11, 16'd10, 1'b0};

        for (int i = 0; i < 7; i++) begin
            send_point(vecs[i].cr, vecs[i].ci, vecs[i].mi, vecs[i].tag, 200, lat);
            tests_run++;
            if (lat !== vecs[i].lat) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d cycles, required %0d", vecs[i].name, lat, vecs[i].lat);
            end
            tests_run++;
            if (iter_o !== vecs[i].iter || escaped_o !== vecs[i].esc) begin
                tests_failed++;
                $display("FAIL %s result: iter=%0d esc=%b, required iter=%0d esc=%b",
                         vecs[i].name, iter_o, escaped_o, vecs[i].iter, vecs[i].esc);
            end
            tests_run++;
            if (tag_o !== vecs[i].tag) begin
                tests_failed++;
                $display("FAIL %s tag: got %h, required %h", vecs[i].name, tag_o, vecs[i].tag);
            end
            release_result();
            tests_run++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s release: valid=%b ready=%b, required valid=0 ready=1",
                         vecs[i].name, valid_o, ready_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit unstable;
        bit ready_seen;
        send_point(Q_ZERO, Q_ZERO, 16'd3, 22'h0AAAA, 50, lat);
        tests_run++;
        if (lat !== 4 || iter_o !== 16'd3) begin
            tests_failed++;
            $display("FAIL bp_first_result: lat=%0d iter=%0d, required lat=4 iter=3", lat, iter_o);
        end
        // Second point waits on the input while the first result is held.
        cr_i = Q_HALF; ci_i = Q_ZERO; max_iter_i = 16'd0; tag_i = 22'h15A5A; valid_i = 1'b1;
        unstable = 1'b0;
        ready_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (valid_o !== 1'b1 || iter_o !== 16'd3 || escaped_o !== 1'b0 || tag_o !== 22'h0AAAA)
                unstable = 1'b1;
            if (ready_o !== 1'b0) ready_seen = 1'b1;
        end
        tests_run++;
        if (unstable) begin
            tests_failed++;
            $display("FAIL bp_hold: valid=%b iter=%0d tag=%h, required held at 1/3/0aaaa", valid_o, iter_o, tag_o);
        end
        tests_run++;
        if (ready_seen) begin
            tests_failed++;
            $display("FAIL bp_ready: ready_o=1 seen while holding a result, required 0");
        end
        release_result();
        tests_run++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_no_same_cycle_accept: valid=%b ready=%b, required valid=0 ready=1",
                     valid_o, ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_second_accept: ready_o=%b, required 0 after accept", ready_o);
        end
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        tests_run++;
        if (lat !== 1 || iter_o !== 16'd0 || escaped_o !== 1'b0 || tag_o !== 22'h15A5A) begin
            tests_failed++;
            $display("FAIL bp_second_result: lat=%0d iter=%0d esc=%b tag=%h, required 1/0/0/15a5a",
                     lat, iter_o, escaped_o, tag_o);
        end
        release_result();
    endtask

    task automatic test_reset_mid_iter();
        int  lat;
        bit  spurious;
        @(negedge clk_i);
        cr_i = Q_ZERO; ci_i = Q_ZERO; max_iter_i = 16'd1000; tag_i = 22'h2F0F0; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (50) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0 || tag_o !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: valid=%b ready=%b tag=%h, required 0/0/0",
                     valid_o, ready_o, tag_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        spurious = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (valid_o !== 1'b0 || ready_o !== 1'b1) spurious = 1'b1;
        end
        tests_run++;
        if (spurious) begin
            tests_failed++;
            $display("FAIL mid_reset_discard: result or busy seen after reset, required idle with valid_o=0");
        end
        send_point(Q_1P5, Q_ZERO, 16'd50, 22'h3C3C3, 50, lat);
        tests_run++;
        if (lat !== 3 || iter_o !== 16'd2 || escaped_o !== 1'b1 || tag_o !== 22'h3C3C3) begin
            tests_failed++;
            $display("FAIL mid_reset_next_point: lat=%0d iter=%0d esc=%b tag=%h, required 3/2/1/3c3c3",
                     lat, iter_o, escaped_o, tag_o);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_directed_vectors();
        test_back_to_back();
        test_reset_mid_iter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
